// File: rtl/flag_parity_zero_unit.sv
// flag_parity_zero_unit: registered status-flag generator for the execute stage.
// It computes x86-style parity of the low result byte and zero detection at 8, 16 and
// 32 bits, and selects the architectural ZF by operand size. Results appear one clock
// after capture.
//
// Optional feature: define PZU_SIGN_FLAG_EN to add the registered sign flag output sf.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   capture strobe for data/op_size
//   data      in   [DATA_W-1:0] ALU/shifter result to evaluate
//   op_size   in   [1:0] 00=8-bit, 01=16-bit, 10=32-bit, 11=reserved
//   out_valid out  registered copy of in_valid
//   pf        out  parity flag (even number of ones in data[7:0])
//   zf        out  zero flag for the selected operand size
//   zero8     out  data[7:0] == 0, independent of op_size
//   zero16    out  data[15:0] == 0, independent of op_size
//   zero32    out  data[31:0] == 0, independent of op_size
//   sf        out  sign bit of the selected size (only with PZU_SIGN_FLAG_EN)
module flag_parity_zero_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        op_size,
  output logic              out_valid,
  output logic              pf,
  output logic              zf,
  output logic              zero8,
  output logic              zero16,
`ifdef PZU_SIGN_FLAG_EN
  output logic              zero32,
  output logic              sf
`else
  output logic              zero32
`endif
);

  // The zero detectors and sign taps are hard-wired to 8/16/32-bit fields.
  if (DATA_W != 32) begin : gen_width_check
    $error("flag_parity_zero_unit supports only DATA_W = 32");
  end

  localparam logic [1:0] Size8   = 2'b00;
  localparam logic [1:0] Size16  = 2'b01;
  localparam logic [1:0] Size32  = 2'b10;

  // Combinational flag computation.
  logic zero8_d, zero16_d, zero32_d;
  logic pf_d, zf_d;

  always_comb begin
    zero8_d  = ~|data[7:0];
    zero16_d = ~|data[15:0];
    zero32_d = ~|data[31:0];
    // PF always uses the low byte regardless of operand size.
    pf_d     = ~^data[7:0];
    zf_d     = 1'b0;
    unique case (op_size)
      Size8:   zf_d = zero8_d;
      Size16:  zf_d = zero16_d;
      Size32:  zf_d = zero32_d;
      default: begin
        // Reserved size forces the architectural flag vector to zero.
        zf_d = 1'b0;
        pf_d = 1'b0;
      end
    endcase
  end

`ifdef PZU_SIGN_FLAG_EN
  logic sf_d;

  always_comb begin
    sf_d = 1'b0;
    unique case (op_size)
      Size8:   sf_d = data[7];
      Size16:  sf_d = data[15];
      Size32:  sf_d = data[31];
      default: sf_d = 1'b0;
    endcase
  end
`endif

  // out_valid tracks in_valid each cycle; flags load only on capture and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pf        <= 1'b0;
      zf        <= 1'b0;
      zero8     <= 1'b0;
      zero16    <= 1'b0;
      zero32    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        pf     <= pf_d;
        zf     <= zf_d;
        zero8  <= zero8_d;
        zero16 <= zero16_d;
        zero32 <= zero32_d;
      end
    end
  end

`ifdef PZU_SIGN_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sf <= 1'b0;
    end else if (in_valid) begin
      sf <= sf_d;
    end
  end
`endif

endmodule

// File: tb/tb_flag_parity_zero_unit.sv
// Self-checking bench for flag_parity_zero_unit. Expected flag vectors are pushed to a
// queue when a capture is driven and popped when the DUT raises out_valid.
// Flag vector layout: {pf, zf, zero8, zero16, zero32, sf}.
module tb_flag_parity_zero_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] data;
  logic [1:0]  op_size;
  logic        out_valid;
  logic        pf, zf, zero8, zero16, zero32;
  logic        sf_obs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [5:0] exp_q[$];
  logic [5:0] last_exp;

`ifdef PZU_SIGN_FLAG_EN
  logic sf;
  assign sf_obs = sf;
`else
  assign sf_obs = 1'b0;
`endif

  flag_parity_zero_unit #(
    .DATA_W(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .data     (data),
    .op_size  (op_size),
    .out_valid(out_valid),
    .pf       (pf),
    .zf       (zf),
    .zero8    (zero8),
    .zero16   (zero16),
`ifdef PZU_SIGN_FLAG_EN
    .zero32   (zero32),
    .sf       (sf)
`else
    .zero32   (zero32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the flag definitions.
  function automatic logic [5:0] model(input logic [31:0] d, input logic [1:0] s);
    logic p, z, z8, z16, z32, sg;
    p   = ($countones(d & 32'h0000_00FF) % 2) == 0;
    z8  = (d & 32'h0000_00FF) == 32'd0;
    z16 = (d & 32'h0000_FFFF) == 32'd0;
    z32 = d == 32'd0;
    case (s)
      2'd0: begin z = z8;  sg = d[7];  end
      2'd1: begin z = z16; sg = d[15]; end
      2'd2: begin z = z32; sg = d[31]; end
      default: begin z = 1'b0; p = 1'b0; sg = 1'b0; end
    endcase
`ifndef PZU_SIGN_FLAG_EN
    sg = 1'b0;
`endif
    return {p, z, z8, z16, z32, sg};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {pf, zf, zero8, zero16, zero32, sf_obs};
  endfunction

  // One clock of stimulus followed by a check #1 after the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] s,
                      input string tag);
    @(negedge clk);
    in_valid = v;
    data     = d;
    op_size  = s;
    if (v) exp_q.push_back(model(d, s));
    @(posedge clk);
    #1;
    check_eq({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, ".queue_nonempty"}, 32'd0, 32'd1);
      end else begin
        last_exp = exp_q.pop_front();
      end
    end
    check_eq({tag, ".flags"}, {26'd0, flags_now()}, {26'd0, last_exp});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data     = 32'd0;
    op_size  = 2'd0;
    last_exp = 6'd0;
    #12;
    check_eq("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset.flags", {26'd0, flags_now()}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Outputs hold reset values until the first capture.
    step(1'b0, 32'hFFFF_FFFF, 2'd2, "idle");

    // Parity.
    step(1'b1, 32'h0000_0003, 2'd2, "par_even");
    step(1'b1, 32'h0000_0007, 2'd2, "par_odd");
    step(1'b1, 32'h1234_5600, 2'd1, "par_hi_ignored");

    // Size masking.
    step(1'b1, 32'hABCD_0000, 2'd0, "mask8");
    step(1'b1, 32'hABCD_0000, 2'd1, "mask16");
    step(1'b1, 32'hABCD_0000, 2'd2, "mask32");
    step(1'b1, 32'hFFFF_FF00, 2'd0, "mask8_upper");

    // Reserved size.
    step(1'b1, 32'h0000_0000, 2'd3, "reserved_zero");
    step(1'b1, 32'h0000_8080, 2'd3, "reserved_sign");

    // Hold then streaming.
    step(1'b1, 32'h0000_0000, 2'd2, "cap_zero");
    for (int i = 0; i < 3; i++) step(1'b0, 32'hFFFF_FFFF, 2'd2, "hold");
    step(1'b1, 32'h0000_0001, 2'd0, "stream0");
    step(1'b1, 32'h0001_0000, 2'd1, "stream1");
    step(1'b1, 32'h8000_0000, 2'd2, "stream2");
    step(1'b1, 32'h0000_00FF, 2'd0, "stream3");

    // Random mix of captures and idle cycles.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rd;
      rd = $urandom();
      if ($urandom_range(0, 2) == 0) rd = rd & 32'hFFFF_0000;
      if ($urandom_range(0, 3) == 0) rd = rd & 32'hFFFF_FF00;
      step(($urandom_range(0, 3) != 0), rd, 2'($urandom_range(0, 3)), "rand");
    end

    // Asynchronous reset in mid-cycle with nonzero outputs.
    step(1'b1, 32'h0000_0000, 2'd2, "pre_reset");
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_reset.flags", {26'd0, flags_now()}, 32'd0);
    exp_q.delete();
    last_exp = 6'd0;
    @(posedge clk);
    #1;
    check_eq("reset_held.flags", {26'd0, flags_now()}, 32'd0);
    #2 rst_n = 1'b1;
    // Capture on the first clock after deassertion.
    step(1'b1, 32'h0000_0080, 2'd0, "first_after_reset");

`ifdef PZU_SIGN_FLAG_EN
    step(1'b1, 32'h0000_8000, 2'd1, "sign16");
    check_eq("sign16.sf", {31'd0, sf}, 32'd1);
    step(1'b1, 32'h0000_8000, 2'd0, "sign8");
    check_eq("sign8.sf", {31'd0, sf}, 32'd0);
`endif

    step(1'b0, 32'd0, 2'd0, "drain");
    check_eq("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_parity_zero_unit.md
Name: flag_parity_zero_unit

Overview:
- Registered status-flag generator for the execute stage.
- Computes x86-style parity of the low result byte, and zero detection at 8, 16 and 32 bits.
- Selects the architectural ZF by operand size.
- Feeds the flag-merge logic after the ALU/shifter; results appear one clock after capture.

Parameters:
- DATA_W, 32, result width; only 32 is supported. Zero detectors are fixed at 8/16/32 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  capture strobe for data/op_size
- data  input  32  ALU/shifter result to evaluate
- op_size  input  2  00=8-bit, 01=16-bit, 10=32-bit, 11=reserved
- out_valid  output  1  registered copy of in_valid
- pf  output  1  parity flag: 1 when data[7:0] has an even number of ones
- zf  output  1  zero flag for the selected size
- zero8  output  1  data[7:0]==0, independent of op_size
- zero16  output  1  data[15:0]==0, independent of op_size
- zero32  output  1  data[31:0]==0, independent of op_size

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset (rst_n low, async): out_valid=0, pf=0, zf=0, zero8=0, zero16=0, zero32=0. Outputs hold these values until the first capture after rst_n deasserts.
- Capture:
  - On a rising clk with in_valid=1, all flag outputs load values computed combinationally from the current data/op_size.
  - Latency is exactly 1 cycle.
  - out_valid is 1 in the cycle after a capture.
- Hold: on a rising clk with in_valid=0, out_valid loads 0 and the flag outputs hold their previous values. There is no back-pressure.
- Parity:
  - pf = NOT(XOR of data[7:0]).
  - Always the low byte, for every op_size including 16/32-bit, per x86 PF rules.
  - For op_size=11, pf=0.
- Zero:
  - zero8/zero16/zero32 are pure all-zero reductions over their field and ignore op_size.
  - zf = zero8 for size 00, zero16 for size 01, zero32 for size 10, 0 for size 11.
- Reserved size (11): pf=0 and zf=0 (flag vector forced to 0). zero8/16/32 still report their raw value.
- Upper-bit masking: bits above the selected size never affect zf; for example, size 00 with data=32'hFFFF_FF00 gives zf=1.
- Back-to-back: in_valid may be high every cycle; each cycle's result appears on the next cycle with no bubbles.
- Reset mid-stream: async assertion clears all outputs immediately, regardless of clk. A capture on the first clk after deassertion is honored.

Optional Feature:
- Macro PZU_SIGN_FLAG_EN.
- When defined:
  - Adds output sf (1 bit), registered under the same capture/hold/reset rules (reset value 0).
  - sf = data[7] for size 00, data[15] for size 01, data[31] for size 10, 0 for size 11.
- When undefined: port sf does not exist and no related logic is built.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with outputs nonzero -> all outputs 0 immediately, before the next clk edge.
- Parity: in_valid=1, op_size=10, data=32'h0000_0003 -> next cycle pf=1, zf=0, out_valid=1. Then data=32'h0000_0007 -> pf=0.
- Size masking:
  - op_size=00, data=32'hABCD_0000 -> zf=1, zero8=1, zero16=1, zero32=0.
  - op_size=01, same data -> zf=1.
  - op_size=10, same data -> zf=0.
- Reserved size: op_size=11, data=0 -> pf=0, zf=0, zero8=zero16=zero32=1.
- Hold and streaming:
  - Capture data=0, size 10 (zf=1, pf=1).
  - Then 3 cycles in_valid=0 with data=32'hFFFF_FFFF -> flags stay zf=1, pf=1; out_valid=1 for one cycle, then 0.
  - Then 4 consecutive captures -> 4 consecutive out_valid pulses with matching flags.
- With PZU_SIGN_FLAG_EN: op_size=01, data=32'h0000_8000 -> sf=1, zf=0. Then op_size=00, same data -> sf=0, zf=1.
